// File: rtl/adder_operand_loader.sv
// Byte-stream operand loader for the external ripple adder: assembles a, b and cin,
// runs one execute cycle, then holds the captured sum/cout/zero on a valid/ready port.
module adder_operand_loader #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    output logic              add_cin,
    input  logic [DATA_W-1:0] add_sum,
    input  logic              add_cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_sum,
    output logic              res_cout,
    output logic              res_zero
);

    localparam int unsigned NBYTES = DATA_W / BYTE_W;
    localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        LOAD_C,
        EXEC,
        HOLD
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic             load_ready;
    logic             load_a, load_b, load_c;
    logic             capture, release_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_A;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        load_ready  = 1'b0;
        load_a      = 1'b0;
        load_b      = 1'b0;
        load_c      = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;

        case (state)
            LOAD_A: begin
                load_ready = 1'b1;
                if (in_valid) begin
                    load_a = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_next = LOAD_B;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            LOAD_B: begin
                load_ready = 1'b1;
                if (in_valid) begin
                    load_b = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_next = LOAD_C;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            LOAD_C: begin
                load_ready = 1'b1;
                if (in_valid) begin
                    load_c     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                capture    = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    release_res = 1'b1;
                    state_next  = LOAD_A;
                    idx_next    = '0;
                end
            end
            default: begin
                state_next = LOAD_A;
                idx_next   = '0;
            end
        endcase

        // Frame abort overrides any beat or result handshake in the same cycle.
        if (clr) begin
            state_next  = LOAD_A;
            idx_next    = '0;
            load_a      = 1'b0;
            load_b      = 1'b0;
            load_c      = 1'b0;
            capture     = 1'b0;
            release_res = 1'b0;
        end
    end

    // Gated with rst_n so the port reads not-ready for the whole reset interval.
    assign in_ready = rst_n & load_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_zero  <= 1'b0;
        end else if (clr) begin
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            if (load_a) begin
                add_a[idx*BYTE_W +: BYTE_W] <= in_data;
            end
            if (load_b) begin
                add_b[idx*BYTE_W +: BYTE_W] <= in_data;
            end
            if (load_c) begin
                add_cin <= in_data[0];
            end
            if (capture) begin
                res_sum   <= add_sum;
                res_cout  <= add_cout;
                res_zero  <= (add_sum == '0);
                res_valid <= 1'b1;
            end else if (release_res) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule
